// File: rtl/dm_cache_ctrl_if.sv
// CPU-side and memory-side signal bundle for dm_cache_ctrl.
// The slave modport is the cache controller; master is the CPU plus memory environment.
interface dm_cache_ctrl_if #(
   parameter int unsigned c_block_size = 2,
   parameter int unsigned c_line_size  = 64,
   parameter int unsigned address_size = 32
);
   localparam int unsigned LINE_W = (1 << c_block_size) * c_line_size;
   localparam int unsigned MADR_W = address_size - c_block_size - 3;

   logic                    cpu_read_i;
   logic                    cpu_wr_i;
   logic [address_size-1:0] cpu_addr_i;
   logic [c_line_size-1:0]  cpu_wr_data_i;
   logic [c_line_size-1:0]  cpu_read_data_o;
   logic                    cpu_busywait_o;
   logic                    c_m_read_o;
   logic                    c_m_wr_o;
   logic [MADR_W-1:0]       c_m_addr_o;
   logic [LINE_W-1:0]       c_m_wr_data_o;
   logic [LINE_W-1:0]       c_m_read_data_i;
   logic                    c_m_busywait_i;
   logic                    c_m_read_done_i;
   logic                    c_m_write_done_i;

   modport master (
      output cpu_read_i, cpu_wr_i, cpu_addr_i, cpu_wr_data_i,
      output c_m_read_data_i, c_m_busywait_i, c_m_read_done_i, c_m_write_done_i,
      input  cpu_read_data_o, cpu_busywait_o, c_m_read_o, c_m_wr_o, c_m_addr_o, c_m_wr_data_o
   );

   modport slave (
      input  cpu_read_i, cpu_wr_i, cpu_addr_i, cpu_wr_data_i,
      input  c_m_read_data_i, c_m_busywait_i, c_m_read_done_i, c_m_write_done_i,
      output cpu_read_data_o, cpu_busywait_o, c_m_read_o, c_m_wr_o, c_m_addr_o, c_m_wr_data_o
   );
endinterface

// File: rtl/dm_cache_ctrl.sv
// Direct-mapped write-back write-allocate cache controller in front of a burst memory.
// Define CACHE_STATS_EN to add hit/miss counters.
module dm_cache_ctrl #(
   parameter int unsigned c_block_size = 2,
   parameter int unsigned c_line_size  = 64,
   parameter int unsigned c_index_size = 3,
   parameter int unsigned address_size = 32
) (
   input logic            c_clk_i,
   input logic            c_reset_i,
   dm_cache_ctrl_if.slave bus
`ifdef CACHE_STATS_EN
   ,
   output logic [31:0]    c_hit_count_o,
   output logic [31:0]    c_miss_count_o
`endif
);
   localparam int unsigned WORDS  = 1 << c_block_size;
   localparam int unsigned LINES  = 1 << c_index_size;
   localparam int unsigned LINE_W = WORDS * c_line_size;
   localparam int unsigned OFF_W  = c_block_size + 3;
   localparam int unsigned TAG_W  = address_size - c_index_size - OFF_W;

   typedef enum logic [1:0] {StIdle, StWriteback, StAllocate, StUpdate} state_e;

   state_e state_q, state_d;

   logic [LINES-1:0]  valid_q, dirty_q;
   logic [TAG_W-1:0]  tag_q  [LINES];
   logic [LINE_W-1:0] data_q [LINES];
   logic [LINE_W-1:0] line_q;

   logic [c_index_size-1:0] idx;
   logic [TAG_W-1:0]        tag;
   logic [c_block_size-1:0] word;
   logic                    req, hit, do_write;
   logic                    unused_bits;

   assign idx         = bus.cpu_addr_i[OFF_W +: c_index_size];
   assign tag         = bus.cpu_addr_i[address_size-1 -: TAG_W];
   assign word        = bus.cpu_addr_i[3 +: c_block_size];
   assign req         = bus.cpu_read_i | bus.cpu_wr_i;
   assign hit         = valid_q[idx] && (tag_q[idx] == tag);
   assign unused_bits = ^{bus.c_m_busywait_i, bus.cpu_addr_i[2:0]};
   assign bus.c_m_wr_data_o = data_q[idx];

   always_comb begin
      state_d             = state_q;
      do_write            = 1'b0;
      bus.cpu_busywait_o  = 1'b0;
      bus.cpu_read_data_o = '0;
      bus.c_m_read_o      = 1'b0;
      bus.c_m_wr_o        = 1'b0;
      bus.c_m_addr_o      = {tag, idx};
      unique case (state_q)
         StIdle: begin
            if (req) begin
               if (hit) begin
                  // Simultaneous read and write is served as a read only.
                  if (bus.cpu_read_i) begin
                     bus.cpu_read_data_o = data_q[idx][word*c_line_size +: c_line_size];
                  end else begin
                     do_write = 1'b1;
                  end
               end else begin
                  bus.cpu_busywait_o = 1'b1;
                  state_d = (valid_q[idx] && dirty_q[idx]) ? StWriteback : StAllocate;
               end
            end
         end
         StWriteback: begin
            bus.cpu_busywait_o = 1'b1;
            bus.c_m_wr_o       = 1'b1;
            bus.c_m_addr_o     = {tag_q[idx], idx};
            if (bus.c_m_write_done_i) state_d = StAllocate;
         end
         StAllocate: begin
            bus.cpu_busywait_o = 1'b1;
            bus.c_m_read_o     = 1'b1;
            if (bus.c_m_read_done_i) state_d = StUpdate;
         end
         StUpdate: begin
            bus.cpu_busywait_o = 1'b1;
            state_d            = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge c_clk_i) begin
      if (c_reset_i) begin
         state_q <= StIdle;
         valid_q <= '0;
         dirty_q <= '0;
      end else begin
         state_q <= state_d;
         if (do_write) dirty_q[idx] <= 1'b1;
         if (state_q == StUpdate) begin
            valid_q[idx] <= 1'b1;
            dirty_q[idx] <= 1'b0;
         end
      end
   end

   // Tag and data arrays are deliberately left uninitialised by reset.
   always_ff @(posedge c_clk_i) begin
      if (!c_reset_i) begin
         if (state_q == StAllocate && bus.c_m_read_done_i) line_q <= bus.c_m_read_data_i;
         if (do_write) data_q[idx][word*c_line_size +: c_line_size] <= bus.cpu_wr_data_i;
         if (state_q == StUpdate) begin
            data_q[idx] <= line_q;
            tag_q[idx]  <= tag;
         end
      end
   end

`ifdef CACHE_STATS_EN
   logic [31:0] hit_cnt_q, miss_cnt_q;
   logic        after_update_q;

   // The hit that retires a miss after refill is not a new hit.
   always_ff @(posedge c_clk_i) begin
      if (c_reset_i) begin
         hit_cnt_q      <= '0;
         miss_cnt_q     <= '0;
         after_update_q <= 1'b0;
      end else begin
         after_update_q <= (state_q == StUpdate);
         if (state_q == StIdle && req && hit && !after_update_q) hit_cnt_q <= hit_cnt_q + 32'd1;
         if (state_q == StIdle && req && !hit) miss_cnt_q <= miss_cnt_q + 32'd1;
      end
   end

   assign c_hit_count_o  = hit_cnt_q;
   assign c_miss_count_o = miss_cnt_q;
`endif
endmodule

// File: tb/tb_dm_cache_ctrl.sv
// Scoreboard bench for dm_cache_ctrl with a latency-based burst memory model.
module tb_dm_cache_ctrl;
   localparam int unsigned MemLat  = 4;
   localparam int unsigned Timeout = 64;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   dm_cache_ctrl_if bus ();
   logic [31:0] hit_count, miss_count;

   dm_cache_ctrl dut (
      .c_clk_i   (clk),
      .c_reset_i (rst),
      .bus       (bus.slave)
`ifdef CACHE_STATS_EN
      ,
      .c_hit_count_o  (hit_count),
      .c_miss_count_o (miss_count)
`endif
   );

   int checks = 0;
   int fails  = 0;
   logic [63:0]  exp_q [$];
   logic [255:0] mem [logic [26:0]];

   int           rd_bursts = 0, wr_bursts = 0, wr_before_rd = 0;
   logic [26:0]  last_rd_addr, last_wr_addr;
   logic [255:0] last_wr_data;

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [255:0] mem_line(input logic [26:0] a);
      logic [255:0] l;
      if (mem.exists(a)) return mem[a];
      for (int k = 0; k < 4; k++) begin
         if (a == 27'h2) l[k*64 +: 64] = 64'(k + 1);
         else            l[k*64 +: 64] = 64'(a) * 64'd16 + 64'(k + 1);
      end
      return l;
   endfunction

   // Memory: answers a request held for MemLat consecutive cycles with a one-cycle done pulse.
   initial begin
      int cnt;
      cnt = 0;
      bus.c_m_read_done_i  = 1'b0;
      bus.c_m_write_done_i = 1'b0;
      bus.c_m_busywait_i   = 1'b0;
      bus.c_m_read_data_i  = '0;
      forever begin
         @(negedge clk);
         if (bus.c_m_read_done_i || bus.c_m_write_done_i) begin
            bus.c_m_read_done_i  = 1'b0;
            bus.c_m_write_done_i = 1'b0;
            cnt = 0;
         end else if (bus.c_m_read_o || bus.c_m_wr_o) begin
            cnt++;
            if (cnt == MemLat) begin
               if (bus.c_m_wr_o) begin
                  wr_bursts++;
                  last_wr_addr = bus.c_m_addr_o;
                  last_wr_data = bus.c_m_wr_data_o;
                  mem[bus.c_m_addr_o] = bus.c_m_wr_data_o;
                  bus.c_m_write_done_i = 1'b1;
               end else begin
                  rd_bursts++;
                  wr_before_rd = wr_bursts;
                  last_rd_addr = bus.c_m_addr_o;
                  bus.c_m_read_data_i = mem_line(bus.c_m_addr_o);
                  bus.c_m_read_done_i = 1'b1;
               end
            end
         end else begin
            cnt = 0;
         end
         bus.c_m_busywait_i = (bus.c_m_read_o || bus.c_m_wr_o) && !bus.c_m_read_done_i
                              && !bus.c_m_write_done_i;
      end
   end

   // Monitor: every completed CPU read is compared against the scoreboard head.
   initial begin
      logic [63:0] e;
      forever begin
         @(negedge clk);
         if (!rst && bus.cpu_read_i && !bus.cpu_busywait_o) begin
            if (exp_q.size() == 0) begin
               checks++;
               fails++;
               $display("FAIL unexpected_read: got %0h expected no read", bus.cpu_read_data_o);
            end else begin
               e = exp_q.pop_front();
               check("read_data", bus.cpu_read_data_o, e);
            end
         end
      end
   end

   task automatic cpu_op(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [63:0] wdata, input logic [63:0] exp, output int cycles);
      @(posedge clk); #1;
      bus.cpu_read_i    = rd;
      bus.cpu_wr_i      = wr;
      bus.cpu_addr_i    = addr;
      bus.cpu_wr_data_i = wdata;
      if (rd) exp_q.push_back(exp);
      cycles = 0;
      @(negedge clk);
      while (bus.cpu_busywait_o && cycles < Timeout) begin
         cycles++;
         @(negedge clk);
      end
      if (bus.cpu_busywait_o) begin
         checks++;
         fails++;
         $display("FAIL op_timeout: got busywait=1 after %0d cycles expected 0", cycles);
      end
      @(posedge clk); #1;
      bus.cpu_read_i = 1'b0;
      bus.cpu_wr_i   = 1'b0;
   endtask

   initial begin
      int cyc, rb, wb, waited;
      bus.cpu_read_i    = 1'b0;
      bus.cpu_wr_i      = 1'b0;
      bus.cpu_addr_i    = '0;
      bus.cpu_wr_data_i = '0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_busywait", bus.cpu_busywait_o, 0);
      check("rst_m_read", bus.c_m_read_o, 0);
      check("rst_m_wr", bus.c_m_wr_o, 0);
      check("rst_read_data", bus.cpu_read_data_o, 0);

      cpu_op(1'b1, 1'b0, 32'h40, 64'h0, 64'h1, cyc);
      check("cold_stalled", cyc > 0, 1);
      check("cold_rd_bursts", rd_bursts, 1);
      check("cold_rd_addr", last_rd_addr, 27'h2);
      check("cold_no_wb", wr_bursts, 0);

      cpu_op(1'b1, 1'b0, 32'h48, 64'h0, 64'h2, cyc);
      check("hit48_cycles", cyc, 0);
      check("hit48_no_burst", rd_bursts, 1);

      cpu_op(1'b0, 1'b1, 32'h50, 64'hDEAD, 64'h0, cyc);
      check("wr50_cycles", cyc, 0);
      cpu_op(1'b1, 1'b0, 32'h50, 64'h0, 64'hDEAD, cyc);
      check("rd50_cycles", cyc, 0);

      cpu_op(1'b1, 1'b0, 32'h440, 64'h0, 64'h221, cyc);
      check("evict_wr_bursts", wr_bursts, 1);
      check("evict_wr_addr", last_wr_addr, 27'h2);
      check("evict_wr_word2", last_wr_data[191:128], 64'hDEAD);
      check("evict_wr_word0", last_wr_data[63:0], 64'h1);
      check("evict_rd_bursts", rd_bursts, 2);
      check("evict_rd_addr", last_rd_addr, 27'h22);
      check("evict_wb_first", wr_before_rd, 1);
`ifdef CACHE_STATS_EN
      check("stats_hits", hit_count, 3);
      check("stats_misses", miss_count, 2);
`endif

      // Reset in the middle of a refill.
      rb = rd_bursts;
      @(posedge clk); #1;
      bus.cpu_read_i = 1'b1;
      bus.cpu_addr_i = 32'h40;
      waited = 0;
      @(negedge clk);
      while (!bus.c_m_read_o && waited < Timeout) begin
         waited++;
         @(negedge clk);
      end
      check("alloc_reached", bus.c_m_read_o, 1);
      #1;
      rst = 1'b1;
      bus.cpu_read_i = 1'b0;
      @(posedge clk); #1;
      check("rstmid_m_read", bus.c_m_read_o, 0);
      check("rstmid_m_wr", bus.c_m_wr_o, 0);
      check("rstmid_busywait", bus.cpu_busywait_o, 0);
`ifdef CACHE_STATS_EN
      check("rstmid_hits", hit_count, 0);
      check("rstmid_misses", miss_count, 0);
`endif
      rst = 1'b0;
      check("rstmid_no_burst", rd_bursts, rb);

      wb = wr_bursts;
      cpu_op(1'b1, 1'b0, 32'h40, 64'h0, 64'h1, cyc);
      check("reread_stalled", cyc > 0, 1);
      check("reread_rd_bursts", rd_bursts, rb + 1);
      check("reread_no_wb", wr_bursts, wb);

      cpu_op(1'b1, 1'b1, 32'h48, 64'hBEEF, 64'h2, cyc);
      check("rdwr_cycles", cyc, 0);
      cpu_op(1'b1, 1'b0, 32'h48, 64'h0, 64'h2, cyc);
      check("rdwr_unchanged_cycles", cyc, 0);

      repeat (2) @(posedge clk);
      check("scoreboard_drained", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end
endmodule
